// File: rtl/philv_pkg.sv
// Shared constants for the philosophy_v instruction fetch path.
package philv_pkg;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned ILEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int unsigned PC_STEP   = 4;
endpackage

// File: rtl/philv_fetch_if.sv
// Bus bundle between the fetch unit, instruction memory and the core.
interface philv_fetch_if #(
    parameter int unsigned XLEN = philv_pkg::XLEN,
    parameter int unsigned ILEN = philv_pkg::ILEN
);
    // valid/ready: a transfer happens on a rising edge where both are high;
    // valid never waits on ready. Responses carry no ready and arrive in order.
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            instr_valid;
    logic            instr_ready;
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
        output redirect_valid, redirect_pc
    );
endinterface

// File: rtl/philv_fetch_fifo.sv
// Synchronous FIFO with flush; flush wins over a same-cycle push or pop.
module philv_fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_data,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && (r_count != CW'(DEPTH)) && !i_flush;
    assign w_do_pop  = i_pop && (r_count != '0) && !i_flush;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
            else if (w_do_pop && !w_do_push) r_count <= r_count - CW'(1);
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
endmodule

// File: rtl/philv_fetch.sv
// Fetch unit: owns the PC, issues credit-limited word fetches, buffers
// in-order responses for the core and drops in-flight data after a redirect.
module philv_fetch #(
    parameter int unsigned    XLEN     = philv_pkg::XLEN,
    parameter int unsigned    ILEN     = philv_pkg::ILEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(philv_pkg::RESET_PC),
    parameter int unsigned    DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    philv_fetch_if.master bus
);
    import philv_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned EW = ILEN + XLEN;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop_cnt;

    logic [CW-1:0]   w_fifo_count;
    logic            w_fifo_empty;
    logic [EW-1:0]   w_head;
    logic [CW:0]     w_used;
    logic            w_req_valid;
    logic            w_req_fire;
    logic            w_rsp_ok;
    logic            w_push;
    logic            w_instr_valid;
    logic            w_pop;
    logic [XLEN-1:0] w_redirect_pc;

    assign w_redirect_pc = bus.redirect_pc & ~XLEN'(3);

    assign w_instr_valid = !w_fifo_empty && !bus.redirect_valid;
    assign w_pop         = w_instr_valid && bus.instr_ready;

    // A pop in this cycle frees its slot for a new request, which is what
    // lets a two-entry budget sustain one instruction per cycle at latency 1.
    assign w_used      = {1'b0, w_fifo_count} + {1'b0, r_outstanding} - {{CW{1'b0}}, w_pop};
    assign w_req_valid = rst_n && (w_used < (CW+1)'(DEPTH)) && !bus.redirect_valid;
    assign w_req_fire  = w_req_valid && bus.imem_req_ready;

    assign w_rsp_ok = bus.imem_rsp_valid && (r_outstanding != '0);
    assign w_push   = w_rsp_ok && (r_drop_cnt == '0) && !bus.redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            if (bus.redirect_valid) begin
                r_pc     <= w_redirect_pc;
                r_rsp_pc <= w_redirect_pc;
            end else begin
                if (w_req_fire) r_pc     <= r_pc + XLEN'(PC_STEP);
                if (w_push)     r_rsp_pc <= r_rsp_pc + XLEN'(PC_STEP);
            end
            r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_rsp_ok);
            // Everything still in flight at a redirect belongs to the old path.
            if (bus.redirect_valid) begin
                r_drop_cnt <= r_outstanding - CW'(w_rsp_ok);
            end else if (w_rsp_ok && (r_drop_cnt != '0)) begin
                r_drop_cnt <= r_drop_cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(bus.imem_rsp_valid && (r_outstanding == '0)))
                else $error("philv_fetch: response with no request outstanding");
        end
    end

    philv_fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (bus.redirect_valid),
        .i_push  (w_push),
        .i_data  ({bus.imem_rsp_data, r_rsp_pc}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_pc;
    assign bus.instr_valid    = w_instr_valid;
    assign bus.instr          = w_fifo_empty ? ILEN'(NOP_INSTR) : w_head[EW-1 -: ILEN];
    assign bus.instr_pc       = w_fifo_empty ? '0 : w_head[XLEN-1:0];
endmodule

// File: doc/philv_fetch.md
Name: philv_fetch

Overview:
Instruction fetch unit that produces the `instr` stream consumed by philosophy_v_core. It owns the PC and issues word-aligned requests to instruction memory. In-order responses are buffered and presented to the core with a valid/ready handshake. A redirect input (branch/jump) flushes the buffer and refetches from a new PC.

Parameters:
XLEN, 32, address/PC width
ILEN, 32, instruction width
RESET_PC, 32'h0000_0000, PC loaded on reset
DEPTH, 2, max instructions in flight plus buffered (power of 2, ≥2)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address (always [1:0]=0)
imem_rsp_valid  in  1  response data valid (in order, latency ≥1 cycle after accept)
imem_rsp_data  in  ILEN  fetched instruction word
instr_valid  out  1  instruction available to core
instr_ready  in  1  core consumes instruction
instr  out  ILEN  instruction to core
instr_pc  out  XLEN  PC of `instr`
redirect_valid  in  1  flush and refetch
redirect_pc  in  XLEN  new fetch target

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0.
  - Outputs during reset: imem_req_valid=0, imem_req_addr=RESET_PC, instr_valid=0, instr=NOP (32'h0000_0013), instr_pc=0.
- Credit: credits = DEPTH − (fifo_count + outstanding − drop_cnt contribution excluded; dropped requests still count as outstanding).
  - imem_req_valid = (credits>0) && !redirect_valid.
  - imem_req_addr = pc.
- Request fire (valid&ready): pc ← pc+4 (wraps 32'hFFFF_FFFC → 0); outstanding+1.
- Response (imem_rsp_valid):
  - outstanding−1.
  - If drop_cnt>0: discard data, drop_cnt−1.
  - Else: push {data, pc_of_request} into FIFO. Each FIFO entry's PC is tracked by a response-PC register advanced +4 per accepted response.
- Output side:
  - instr_valid = FIFO non-empty && !redirect_valid.
  - instr/instr_pc = FIFO head; when empty, instr=NOP and instr_pc=0.
  - Pop on instr_valid&&instr_ready.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - Zero-latency bypass is not required: first instruction appears the cycle after the response.
- Redirect (redirect_valid=1, one cycle):
  - FIFO flushed.
  - pc ← {redirect_pc[XLEN-1:2],2'b00}; response-PC register ← same value.
  - drop_cnt ← outstanding − (imem_rsp_valid this cycle ? 1 : 0). A response arriving in the redirect cycle is discarded.
  - No request issued and no instruction handed over in the redirect cycle.
  - Consecutive redirects: the last one wins.
- Response with outstanding=0 is a protocol violation: ignored, and a simulation-only $display error is raised.
- FIFO never overflows by construction (credit check). A bench check asserts fifo_count+outstanding ≤ DEPTH every cycle.
- Latency: request accept → response (memory latency L) → instr_valid at L+1 cycles after accept. Sustains 1 instr/cycle with L=1 and DEPTH≥2.

Decomposition:
- philv_pkg: XLEN, ILEN, RESET_PC default, NOP_INSTR=32'h0000_0013, PC_STEP=4.
- Sub-module philv_fetch_fifo (synchronous FIFO, width ILEN+XLEN, DEPTH entries, flush input, count output). Used by philv_fetch for the response buffer.
- Credit counter, drop counter and PC logic stay in philv_fetch.

Test Plan:
- Reset: rst_n low mid-stream with 2 outstanding → all outputs at reset values immediately (async). After release, first imem_req_addr=0x0, and stale responses are not delivered.
- Streaming: memory L=1, always ready, instr_ready=1 → instr_pc 0x0,0x4,0x8,… with one instr per cycle after a 2-cycle fill; instr equals memory word at each address.
- Backpressure: instr_ready=0 with DEPTH=2 → exactly 2 requests (0x0, 0x4) then imem_req_valid=0. Release ready → requests resume at 0x8, no loss or duplicate.
- Redirect with in-flight: L=3, 2 outstanding, redirect_pc=0x100 → both late responses dropped, next delivered instr_pc=0x100, then 0x104.
- Misaligned redirect and wrap: redirect_pc=0xFFFF_FFFE → fetch 0xFFFF_FFFC then 0x0000_0000; instr_pc matches.
- Simultaneous: redirect in the same cycle as a response and instr_ready=1 → response discarded, no handoff that cycle, FIFO empty next cycle.
